// File: rtl/rflp_param_sram_if.sv
// Command/response bundle for the parametrised single-port register file.
// Carries chip/write enables, split row/column address, data and bit mask,
// plus registered read data, its valid pulse and the clear-busy status.
interface rflp_param_sram_if #(
    parameter int DATA_W = 22,
    parameter int RA_W   = 6,
    parameter int CA_W   = 2
);
    logic              NCE;
    logic              NWRT;
    logic [RA_W-1:0]   RA;
    logic [CA_W-1:0]   CA;
    logic [DATA_W-1:0] DIN;
    logic [DATA_W-1:0] NBWE;
    logic [DATA_W-1:0] DO;
    logic              DVALID;
    logic              BUSY;

    modport master (
        output NCE, NWRT, RA, CA, DIN, NBWE,
        input  DO, DVALID, BUSY
    );

    modport slave (
        input  NCE, NWRT, RA, CA, DIN, NBWE,
        output DO, DVALID, BUSY
    );
endinterface

// File: rtl/rflp_param_sram.sv
// Single-port register file with per-bit write mask, optional write-through and post-reset clear.
// Latency: read data on DO READ_LAT (1 or 2) edges after the command edge; writes visible next edge.
// No backpressure: one command per edge at full rate; commands are dropped while BUSY (clearing).
module rflp_param_sram #(
    parameter int DATA_W     = 22,
    parameter int RA_W       = 6,
    parameter int CA_W       = 2,
    parameter int READ_LAT   = 1,
    parameter int WRITE_THRU = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic               CLK,
    input  logic               RST,
    rflp_param_sram_if.slave   bus
);
    localparam int AW    = RA_W + CA_W;
    localparam int DEPTH = 1 << AW;

    generate
        if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
            $error("rflp_param_sram: READ_LAT must be 1 or 2");
        end
    endgenerate

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state;
    logic [AW-1:0]     cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy_q;
    logic [DATA_W-1:0] do_q;
    logic              dvalid_q;
    logic              s1_vld;
    logic [DATA_W-1:0] s1_dat;

    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;
    logic              cmd_wr;
    logic              cmd_rd;
    logic              cmd_x;
    logic              pipe_vld;
    logic [DATA_W-1:0] pipe_dat;

    assign addr    = {bus.RA, bus.CA};
    assign rd_word = mem[addr];
    assign merged  = (rd_word & bus.NBWE) | (bus.DIN & ~bus.NBWE);

    assign bus.DO     = do_q;
    assign bus.DVALID = dvalid_q;
    assign bus.BUSY   = busy_q;

    // Decode the command; unknown enables fall to the default arm (corrupt access in simulation).
    always_comb begin
        cmd_wr = 1'b0;
        cmd_rd = 1'b0;
        cmd_x  = 1'b0;
        if (state == S_IDLE) begin
            case ({bus.NCE, bus.NWRT})
                2'b00:        cmd_wr = 1'b1;
                2'b01:        cmd_rd = 1'b1;
                2'b10, 2'b11: ;
                default:      cmd_x  = 1'b1;
            endcase
        end
    end

    // Word entering the output pipeline: read data, or the merged word when write-through is on.
    always_comb begin
        pipe_vld = cmd_rd || (cmd_wr && (WRITE_THRU != 0));
        pipe_dat = cmd_rd ? rd_word : merged;
    end

    // Array update: clear sweep, masked write, or poisoning on a corrupt access; reset leaves it alone.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == S_CLEAR) begin
                mem[cnt] <= '0;
            end else if (cmd_wr) begin
                mem[addr] <= merged;
            end else if (cmd_x) begin
                mem[addr] <= 'x;
            end
        end
    end

    // Control FSM with registered BUSY, clear counter and the read-data pipeline.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
            cnt      <= '0;
            busy_q   <= (INIT_CLEAR != 0);
            do_q     <= '0;
            dvalid_q <= 1'b0;
            s1_vld   <= 1'b0;
            s1_dat   <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    cnt      <= cnt + 1'b1;
                    dvalid_q <= 1'b0;
                    s1_vld   <= 1'b0;
                    if (cnt == {AW{1'b1}}) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    if (READ_LAT == 1) begin
                        if (cmd_x) begin
                            do_q     <= 'x;
                            dvalid_q <= 1'bx;
                        end else begin
                            dvalid_q <= pipe_vld;
                            if (pipe_vld) begin
                                do_q <= pipe_dat;
                            end
                        end
                    end else begin
                        if (cmd_x) begin
                            s1_vld <= 1'bx;
                            s1_dat <= 'x;
                        end else begin
                            s1_vld <= pipe_vld;
                            if (pipe_vld) begin
                                s1_dat <= pipe_dat;
                            end
                        end
                        dvalid_q <= s1_vld;
                        if (s1_vld) begin
                            do_q <= s1_dat;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rflp_param_sram.sv
// Bench for rflp_param_sram: two instances share one command stream.
// dut_a: READ_LAT=1, WRITE_THRU=0; dut_b: READ_LAT=2, WRITE_THRU=1; both clear after reset.
module tb_rflp_param_sram;
    logic CLK;
    logic RST;

    int n_assert = 0;
    int n_fail   = 0;

    rflp_param_sram_if #(.DATA_W(22), .RA_W(6), .CA_W(2)) bus_a ();
    rflp_param_sram_if #(.DATA_W(22), .RA_W(6), .CA_W(2)) bus_b ();

    assign bus_b.NCE  = bus_a.NCE;
    assign bus_b.NWRT = bus_a.NWRT;
    assign bus_b.RA   = bus_a.RA;
    assign bus_b.CA   = bus_a.CA;
    assign bus_b.DIN  = bus_a.DIN;
    assign bus_b.NBWE = bus_a.NBWE;

    rflp_param_sram #(.DATA_W(22), .RA_W(6), .CA_W(2), .READ_LAT(1), .WRITE_THRU(0), .INIT_CLEAR(1))
        dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
    rflp_param_sram #(.DATA_W(22), .RA_W(6), .CA_W(2), .READ_LAT(2), .WRITE_THRU(1), .INIT_CLEAR(1))
        dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: storage contents, clear edges left, and what each output should be holding.
    logic [21:0] mem_m [256];
    int          busy_left;
    int          prev_kind;      // command accepted on the previous edge: 0 none, 1 read, 2 write
    logic [21:0] prev_dat;
    logic [21:0] held_a, held_b;
    logic        exp_vld_a, exp_vld_b;

    task automatic check(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic nce, input logic nwrt, input logic [7:0] a,
                           input logic [21:0] din, input logic [21:0] nbwe);
        bus_a.NCE  = nce;
        bus_a.NWRT = nwrt;
        bus_a.RA   = a[7:2];
        bus_a.CA   = a[1:0];
        bus_a.DIN  = din;
        bus_a.NBWE = nbwe;
    endtask

    task automatic idle();
        set_cmd(1'b1, 1'b1, 8'h00, 22'h0, 22'h3FFFFF);
    endtask

    // One clock edge: advance the model from the sampled command, then compare all outputs.
    task automatic step();
        int          kind;
        logic [21:0] dat;
        logic [7:0]  a;
        @(posedge CLK);
        a    = {bus_a.RA, bus_a.CA};
        kind = 0;
        dat  = '0;
        if (busy_left > 0) begin
            busy_left--;
        end else if (bus_a.NCE == 1'b0) begin
            if (bus_a.NWRT) begin
                kind = 1;
                dat  = mem_m[a];
            end else begin
                kind     = 2;
                dat      = (mem_m[a] & bus_a.NBWE) | (bus_a.DIN & ~bus_a.NBWE);
                mem_m[a] = dat;
            end
        end
        exp_vld_a = (kind == 1);
        if (exp_vld_a) held_a = dat;
        exp_vld_b = (prev_kind != 0);
        if (exp_vld_b) held_b = prev_dat;
        prev_kind = kind;
        prev_dat  = dat;
        #1;
        check("a_do",     bus_a.DO,            held_a);
        check("a_dvalid", {21'd0, bus_a.DVALID}, {21'd0, exp_vld_a});
        check("a_busy",   {21'd0, bus_a.BUSY},   {21'd0, busy_left > 0});
        check("b_do",     bus_b.DO,            held_b);
        check("b_dvalid", {21'd0, bus_b.DVALID}, {21'd0, exp_vld_b});
        check("b_busy",   {21'd0, bus_b.BUSY},   {21'd0, busy_left > 0});
    endtask

    // Assert reset now (away from an edge), check outputs at once, hold for n edges, release.
    task automatic do_reset(input int n);
        RST = 1'b1;
        held_a    = '0;
        held_b    = '0;
        prev_kind = 0;
        busy_left = 256;
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        #1;
        check("rst_a_do",     bus_a.DO,              22'h0);
        check("rst_a_dvalid", {21'd0, bus_a.DVALID}, 22'h0);
        check("rst_a_busy",   {21'd0, bus_a.BUSY},   22'h1);
        check("rst_b_do",     bus_b.DO,              22'h0);
        check("rst_b_dvalid", {21'd0, bus_b.DVALID}, 22'h0);
        check("rst_b_busy",   {21'd0, bus_b.BUSY},   22'h1);
        repeat (n) @(posedge CLK);
        #2;
        RST = 1'b0;
    endtask

    initial begin
        idle();
        do_reset(2);

        // Clear sweep; a write issued on clear edge 10 must be dropped.
        for (int i = 0; i < 256; i++) begin
            if (i == 9) set_cmd(1'b0, 1'b0, 8'h03, 22'h155555, 22'h0);
            else        idle();
            step();
        end

        // Last word reads back zero.
        set_cmd(1'b0, 1'b1, 8'hFF, 22'h0, 22'h3FFFFF);
        step();
        check("clr_last_a", bus_a.DO, 22'h000000);
        idle();
        step();
        check("clr_last_b", bus_b.DO, 22'h000000);

        // Write then immediate read at the top address.
        set_cmd(1'b0, 1'b0, 8'hFF, 22'h2AAAAA, 22'h0);
        step();
        set_cmd(1'b0, 1'b1, 8'hFF, 22'h0, 22'h3FFFFF);
        step();
        check("lat1_do", bus_a.DO, 22'h2AAAAA);
        check("lat1_dv", {21'd0, bus_a.DVALID}, 22'h1);
        idle();
        step();
        check("lat2_do", bus_b.DO, 22'h2AAAAA);
        check("lat2_dv", {21'd0, bus_b.DVALID}, 22'h1);

        // Address written during clear holds zero.
        set_cmd(1'b0, 1'b1, 8'h03, 22'h0, 22'h3FFFFF);
        step();
        check("clr_drop", bus_a.DO, 22'h000000);

        // Per-bit mask: only the low byte is cleared.
        set_cmd(1'b0, 1'b0, 8'h05, 22'h3FFFFF, 22'h0);
        step();
        set_cmd(1'b0, 1'b0, 8'h05, 22'h0, 22'h3FFF00);
        step();
        set_cmd(1'b0, 1'b1, 8'h05, 22'h0, 22'h3FFFFF);
        step();
        check("mask_do", bus_a.DO, 22'h3FFF00);
        idle();
        step();

        // Write-through on dut_b; dut_a holds its previous read value.
        set_cmd(1'b0, 1'b0, 8'h07, 22'h012345, 22'h0);
        step();
        check("nowt_dv", {21'd0, bus_a.DVALID}, 22'h0);
        idle();
        step();
        check("wt_do",   bus_b.DO, 22'h012345);
        check("wt_dv",   {21'd0, bus_b.DVALID}, 22'h1);
        check("nowt_do", bus_a.DO, 22'h3FFF00);

        // Randomized traffic over a small address window to force reuse.
        for (int i = 0; i < 400; i++) begin
            set_cmd(($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                    8'($urandom_range(0, 15)), 22'($urandom), 22'($urandom));
            step();
        end

        // Reset one cycle after a read on the two-cycle instance: no late DVALID, fresh clear.
        set_cmd(1'b0, 1'b1, 8'h07, 22'h0, 22'h3FFFFF);
        step();
        idle();
        do_reset(1);
        for (int i = 0; i < 260; i++) step();

        set_cmd(1'b0, 1'b1, 8'h07, 22'h0, 22'h3FFFFF);
        step();
        idle();
        step();
        check("post_rst_b", bus_b.DO, 22'h000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rflp_param_sram.md
Name: rflp_param_sram

Overview:
Parametrised successor to the fixed 256x22 mux-4 single-port register file. It is synthesizable, with configurable data width and row/column address split. It adds:
- per-bit write masking
- selectable read latency (1 or 2 cycles)
- optional write-through output
- a post-reset hardware clear sequence with BUSY status

It sits between the datapath controllers and storage, and is a drop-in for the old register file when DATA_W=22, RA_W=6, CA_W=2, READ_LAT=1, WRITE_THRU=0, INIT_CLEAR=0.

Parameters:
DATA_W, 22, word width in bits
RA_W, 6, row address width
CA_W, 2, column address width; DEPTH = 2^(RA_W+CA_W)
READ_LAT, 1, read latency in clock edges (1 or 2; other values illegal, elaboration error)
WRITE_THRU, 0, 1 = a write also drives the merged new word onto DO
INIT_CLEAR, 1, 1 = zero the whole array after reset release

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
NCE  input  1  chip enable, active low
NWRT  input  1  0 = write, 1 = read (when NCE=0)
RA  input  RA_W  row address
CA  input  CA_W  column address
DIN  input  DATA_W  write data
NBWE  input  DATA_W  per-bit write enable, active low (0 = bit written)
DO  output  DATA_W  read data, registered
DVALID  output  1  one-cycle pulse, DO carries new read/write-through data
BUSY  output  1  clear sequence in progress; commands ignored

Behaviour:
- Clock and reset: one clock (CLK); RST asynchronous, active-high.
- Address: A = {RA, CA}. All DEPTH addresses are valid; there is no out-of-range case.
- Reset (async, RST=1):
  - DO=0, DVALID=0, all pipeline registers=0.
  - Clear counter=0.
  - BUSY=1 if INIT_CLEAR=1, else BUSY=0.
  - Array contents are not altered by RST itself.
- FSM states: CLEAR, IDLE.
  - Reset enters CLEAR if INIT_CLEAR=1, else IDLE.
  - CLEAR: each rising edge after RST release writes 0 to array[cnt] and increments cnt. When cnt reaches DEPTH-1 that edge writes the last word, then the FSM enters IDLE and BUSY=0.
  - BUSY is high for exactly DEPTH rising edges after release.
  - IDLE: commands sampled every rising edge.
- Command decode at edge N, IDLE only:
  - NCE=1: no-op. DO holds, no DVALID.
  - Write (NCE=0, NWRT=0): array[A] <= (array[A] & NBWE) | (DIN & ~NBWE). The update is visible to a read sampled at edge N+1.
    - WRITE_THRU=1: the merged word travels the read pipeline, so DO/DVALID behave as for a read.
    - WRITE_THRU=0: DO holds and DVALID=0.
  - Read (NCE=0, NWRT=1): array[A] is presented on DO with a DVALID pulse.
    - READ_LAT=1: DO valid after edge N.
    - READ_LAT=2: DO valid after edge N+1.
    - DO holds its last value until the next read or write-through; back-to-back reads are supported at full rate.
- Commands during CLEAR are dropped entirely: no array change, no DVALID, and no queuing.
- RST mid-clear: the counter restarts at 0 and the full DEPTH-cycle clear repeats.
- RST mid-read: the in-flight pipeline stage is flushed and no DVALID is produced for it.
- X/Z on NCE or NWRT in IDLE: the array at A is set to all-X, DO=X, and DVALID=X. This is simulation-only modelling of a corrupt access.

Test Plan:
1. Clear sequence (default parameters, 256 words): pulse RST for 2 cycles and release.
   - Required: BUSY=1 for exactly 256 rising edges, then 0.
   - Then read RA=6'h3F, CA=2'h3 -> DO=22'h000000 with a DVALID pulse.
2. Write/read latency: write DIN=22'h2AAAAA, NBWE=0 at A=8'hFF, then read A=8'hFF at the next edge.
   - READ_LAT=1: DO=22'h2AAAAA, DVALID=1 exactly one edge after the read.
   - READ_LAT=2: the same, two edges after the read.
3. Bit mask: A=5 holds 22'h3FFFFF; write DIN=0, NBWE=22'h3FFF00.
   - Required: read A=5 -> 22'h3FFF00.
4. Write-through: WRITE_THRU=1, write 22'h012345 at A=7 -> DO=22'h012345, DVALID=1 at read latency.
   - Repeat with WRITE_THRU=0 -> DO keeps its prior value, DVALID stays 0.
5. Commands during CLEAR: issue a write of 22'h155555 at A=3 on cycle 10 of CLEAR.
   - Required: after BUSY falls, read A=3 -> 22'h000000.
6. Reset during read: READ_LAT=2, assert RST one cycle after a read command.
   - Required: DO=0 and DVALID=0 immediately; no late DVALID; BUSY high for a fresh 256 edges.
